dmem_responder: RTL
===================

# dmem_responder

Data-memory responder serving the core's load/store port. It accepts one request at a time carrying the write byte enables and read size/sign controls that the decode/control stage produces. It models a word-organised SRAM with a configurable number of wait states, then returns aligned, sign- or zero-extended load data over a valid/ready response channel. It sits between the core's memory stage and the on-chip data RAM.

## Interface
- DEPTH_WORDS, default 1024, number of 32-bit words; must be a power of two.
- LATENCY, default 2, wait-state cycles between accept and memory access; legal range 1..15.
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset. Asynchronous assert, active-low; applies to all state.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request.
- req_addr, input, 32, byte address; bits above log2(DEPTH_WORDS)+2 are ignored.
- req_wdata, input, 32, store data, right-justified.
- req_wbe, input, 4, store enables in low-justified form: 0001 byte, 0011 half, 1111 word. 0000 means load.
- req_rsize, input, 2, load size: 00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned, input, 1, zero-extend load (1) or sign-extend (0).
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_rdata, output, 32, extended load data; 0 for stores and errors.
- rsp_err, output, 1, misaligned access.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, latch all request fields and go to WAIT with the counter set to LATENCY-1.
- WAIT: req_ready=0. The counter decrements each cycle.
  - At count 0, perform the memory access and go to RESP.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err stable.
  - On rsp_ready, go to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- Stores:
  - The effective enable is req_wbe shifted left by addr[1:0].
  - Write data is shifted left by 8*addr[1:0].
  - Only enabled bytes of the addressed word are updated.
  - The response carries rdata=0.
- Loads:
  - Read the word and shift right by 8*addr[1:0].
  - Extract the byte, halfword or word, then extend per req_unsigned.
- Misalignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0, for a load or a store. Behaviour is set under Configuration.
- Memory contents are not reset. Reads of never-written words return X in simulation; the bench must not depend on them.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Accept at edge N, then memory access at edge N+LATENCY.
- rsp_valid is high from edge N+LATENCY until the handshake edge.
- Minimum request-to-request spacing is LATENCY+2 cycles.
- A store is committed only at the access edge. If reset asserts before that edge, the store is dropped and the FSM returns to IDLE.
- Backpressure: while rsp_ready=0, the FSM holds RESP indefinitely with outputs unchanged.
- req_valid during WAIT or RESP is ignored; it is not captured.
- A load issued after a store returns the stored data, because requests are strictly serialised.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - A misaligned access sets rsp_err=1 and rsp_rdata=0.
  - For a misaligned store, no bytes are written.
  - The response latency is unchanged.
- Macro undefined:
  - addr[1:0] is forced to the size's natural alignment: half clears bit 0, word clears both bits.
  - The access proceeds on the aligned address.
  - rsp_err is tied to 0.

## Structure
- Shared package dmem_pkg holds:
  - The FSM state enum.
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - WBE constants WBE_B=4'b0001, WBE_H=4'b0011, WBE_W=4'b1111.
- One combinational sub-module, dmem_load_align, performs the shift, extract and extend, given word, offset, size and unsigned.
- The top level holds the FSM, counter, request registers, memory array and write-enable generation.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid rising exactly LATENCY cycles after the accept edge.
- After that store, load byte signed at 0x13 → 0xFFFFFFDE; load byte unsigned at 0x13 → 0x000000DE; load half signed at 0x12 → 0xFFFFDEAD.
- Store byte 0x55 to 0x11 (wbe 0001), then load word from 0x10 → 0xDEAD55EF.
- Store half to 0x11 with the macro defined → rsp_err=1 and memory unchanged (reload gives 0xDEAD55EF). With the macro undefined → the write goes to 0x10 and rsp_err=0.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable, req_ready=0, and a concurrent req_valid is not captured.
- Assert rst_n=0 in WAIT during a store of 0x12345678 to 0x20 → outputs return to reset values immediately, and a later load of 0x20 returns its prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] WBE_B = 4'b0001;
    localparam logic [3:0] WBE_H = 4'b0011;
    localparam logic [3:0] WBE_W = 4'b1111;

    // Access size of a request. Stores take their size from the enable
    // pattern; loads from rsize, with the reserved code 11 read as a word.
    function automatic logic [1:0] eff_size(input logic [3:0] wbe,
                                            input logic [1:0] rsize);
        logic [1:0] sz;
        if (wbe == 4'b0000)
            sz = (rsize == 2'b11) ? SZ_WORD : rsize;
        else if (wbe == WBE_W)
            sz = SZ_WORD;
        else if (wbe == WBE_H)
            sz = SZ_HALF;
        else
            sz = SZ_BYTE;
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

    // Round the byte offset down to the natural alignment of the size.
    function automatic logic [1:0] align_off(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [1:0] o;
        case (size)
            SZ_HALF: o = {off[1], 1'b0};
            SZ_WORD: o = 2'b00;
            default: o = off;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data aligner: shifts the read word down by the byte offset, extracts
// the byte/half/word and sign- or zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: word (raw SRAM word), off (byte offset), size (SZ_*), is_unsigned,
//        data (extended result).
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {off, 3'b000};
        data    = shifted;
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store against a word SRAM
// with LATENCY wait states. Access happens LATENCY edges after accept.
// Backpressure: holds RESP with stable outputs while rsp_ready is low;
// req_ready is low from accept until the cycle after the response handshake.
// Ports: clk/rst_n; request channel req_valid/req_ready with req_addr,
//        req_wdata, req_wbe (0000 = load), req_rsize, req_unsigned;
//        response channel rsp_valid/rsp_ready with rsp_rdata, rsp_err.
// Build option: define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses
// with rsp_err instead of silently aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wbe,
    input  logic [1:0]  req_rsize,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t state;
    logic [3:0]    cnt;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wbe;
    logic          r_unsigned;
    logic          r_err;

    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits are outside the array and intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:AW+2]};

    // Request-side decode used when latching.
    logic [1:0] in_size;
    logic [1:0] in_off;
    logic       in_err;

    always_comb begin
        in_size = eff_size(req_wbe, req_rsize);
`ifdef DMEM_MISALIGN_CHECK_EN
        in_off  = req_addr[1:0];
        in_err  = is_misaligned(in_size, req_addr[1:0]);
`else
        in_off  = align_off(in_size, req_addr[1:0]);
        in_err  = 1'b0;
`endif
    end

    // Access-edge controls. A flagged access never writes.
    logic        access;
    logic [3:0]  wr_en;
    logic [31:0] wr_data;
    logic [7:0]  wbe_wide;

    always_comb begin
        access   = (state == ST_WAIT) && (cnt == 4'd0);
        wbe_wide = {4'b0000, r_wbe} << r_off;
        wr_en    = (access && !r_err) ? wbe_wide[3:0] : 4'b0000;
        wr_data  = r_wdata << {r_off, 3'b000};
    end

    logic [31:0] ld_data;

    dmem_load_align u_align (
        .word        (mem[r_idx]),
        .off         (r_off),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .data        (ld_data)
    );

    // SRAM contents are deliberately not reset; an async reset moves the
    // FSM out of WAIT so an in-flight store never reaches its access edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b])
                mem[r_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            r_idx      <= '0;
            r_off      <= 2'b00;
            r_size     <= SZ_BYTE;
            r_wdata    <= 32'h0;
            r_wbe      <= 4'b0000;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_idx      <= req_addr[AW+1:2];
                        r_off      <= in_off;
                        r_size     <= in_size;
                        r_wdata    <= req_wdata;
                        r_wbe      <= req_wbe;
                        r_unsigned <= req_unsigned;
                        r_err      <= in_err;
                        cnt        <= CNT_INIT;
                        req_ready  <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= r_err;
                        // Stores and flagged accesses return zero data.
                        rsp_rdata <= (r_err || (r_wbe != 4'b0000)) ? 32'h0 : ld_data;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
